load_store_sequencer: RTL and testbench

Initiator side of the byte-wide data memory port. It accepts one load/store request at a time from the CPU datapath: byte, half or word, signed or unsigned. Each request becomes a sequence of single-byte memory accesses in big-endian order, most-significant byte at the lowest address. For loads it reassembles and sign- or zero-extends the result, then reports completion with `done_o`. Misaligned and out-of-range requests are rejected before any memory traffic.

---
 rtl/load_store_sequencer.sv | 179 +++++++++++++++++
 tb/tb_load_store_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_sequencer.sv
// ---------------------------------------------------------------------------
// load_store_sequencer : byte-serial big-endian load/store initiator | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [1:0]        MemNum_i,
  input  logic              UnSigned_i,
  output logic [31:0]       data_o,
  output logic              done_o,
  output logic              error_misalign_o,
  output logic              error_overflow_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [7:0]        mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RTAIL  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_data;
  logic [31:0] r_acc;
  logic [1:0]  r_size;
  logic [1:0]  r_k;
  logic [1:0]  r_last;
  logic        r_uns;
  logic        r_load;

  logic [2:0]  w_n;
  logic [1:0]  w_last;
  logic [32:0] w_sum;
  logic        w_noop;
  logic        w_mis;
  logic        w_ovf;
  logic [31:0] w_acc_next;

  always_comb begin
    w_n    = 3'd0;
    w_last = 2'd0;
    case (MemNum_i)
      2'b11:   begin w_n = 3'd4; w_last = 2'd3; end
      2'b10:   begin w_n = 3'd2; w_last = 2'd1; end
      2'b01:   begin w_n = 3'd1; w_last = 2'd0; end
      default: begin w_n = 3'd0; w_last = 2'd0; end
    endcase
  end

  // 33-bit sum so an address near 2^32 cannot wrap back into range
  assign w_sum      = {1'b0, addr_i} + {30'd0, w_n};
  assign w_noop     = (MemNum_i == 2'b00) || (MemRead_i == MemWrite_i);
  assign w_mis      = ((MemNum_i == 2'b10) && addr_i[0]) ||
                      ((MemNum_i == 2'b11) && (addr_i[1:0] != 2'b00));
  assign w_ovf      = w_sum > (33'd1 << ADDR_W);
  assign w_acc_next = {r_acc[23:0], mem_rdata_i};

  function automatic logic [7:0] sel_byte(input logic [31:0] d, input logic [1:0] idx);
    case (idx)
      2'd3:    sel_byte = d[31:24];
      2'd2:    sel_byte = d[23:16];
      2'd1:    sel_byte = d[15:8];
      default: sel_byte = d[7:0];
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] v);
    case (sz)
      2'b11:   extend = v;
      2'b10:   extend = {{16{~uns & v[15]}}, v[15:0]};
      default: extend = {{24{~uns & v[7]}}, v[7:0]};
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= S_IDLE;
      r_data           <= 32'd0;
      r_acc            <= 32'd0;
      r_size           <= 2'd0;
      r_k              <= 2'd0;
      r_last           <= 2'd0;
      r_uns            <= 1'b0;
      r_load           <= 1'b0;
      req_ready_o      <= 1'b1;
      data_o           <= 32'd0;
      done_o           <= 1'b0;
      error_misalign_o <= 1'b0;
      error_overflow_o <= 1'b0;
      mem_addr_o       <= '0;
      mem_wdata_o      <= 8'd0;
      mem_we_o         <= 1'b0;
      mem_re_o         <= 1'b0;
    end else begin
      done_o   <= 1'b0;
      mem_we_o <= 1'b0;
      mem_re_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            req_ready_o      <= 1'b0;
            r_data           <= data_i;
            r_size           <= MemNum_i;
            r_uns            <= UnSigned_i;
            r_load           <= MemRead_i;
            r_last           <= w_last;
            r_k              <= 2'd0;
            r_acc            <= 32'd0;
            error_misalign_o <= 1'b0;
            error_overflow_o <= 1'b0;
            if (w_noop) begin
              r_state <= S_DONE;
              done_o  <= 1'b1;
            end else if (w_mis || w_ovf) begin
              error_misalign_o <= w_mis;
              error_overflow_o <= w_ovf;
              r_state          <= S_DONE;
              done_o           <= 1'b1;
            end else begin
              // First byte is issued on the accept edge so it appears in cycle 1
              r_state    <= S_ACCESS;
              mem_addr_o <= addr_i[ADDR_W-1:0];
              if (MemRead_i) begin
                mem_re_o <= 1'b1;
              end else begin
                mem_we_o    <= 1'b1;
                mem_wdata_o <= sel_byte(data_i, w_last);
              end
            end
          end
        end
        S_ACCESS: begin
          if (r_load && (r_k != 2'd0)) r_acc <= w_acc_next;
          if (r_k == r_last) begin
            r_state <= r_load ? S_RTAIL : S_DONE;
            done_o  <= ~r_load;
          end else begin
            r_k        <= r_k + 2'd1;
            mem_addr_o <= mem_addr_o + ADDR_W'(1);
            if (r_load) begin
              mem_re_o <= 1'b1;
            end else begin
              mem_we_o    <= 1'b1;
              mem_wdata_o <= sel_byte(r_data, r_last - (r_k + 2'd1));
            end
          end
        end
        S_RTAIL: begin
          data_o  <= extend(r_size, r_uns, w_acc_next);
          r_state <= S_DONE;
          done_o  <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_sequencer.sv
// ---------------------------------------------------------------------------
// tb_load_store_sequencer : directed bench with a 1 KiB byte memory | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_sequencer;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_num;
  logic              uns;
  logic [31:0]       data_o;
  logic              done;
  logic              err_mis;
  logic              err_ovf;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_wdata;
  logic              m_we;
  logic              m_re;
  logic [7:0]        m_rdata = 8'h00;

  logic [7:0] mem [0:1023] = '{default: 8'h00};

  int errors = 0;
  int checks = 0;

  int   dc, wec, rec;
  logic mis1, ovf1;
  int   extra_done, extra_we;

  always #5 clk = ~clk;

  load_store_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .addr_i           (addr),
    .data_i           (wdata),
    .MemRead_i        (mem_read),
    .MemWrite_i       (mem_write),
    .MemNum_i         (mem_num),
    .UnSigned_i       (uns),
    .data_o           (data_o),
    .done_o           (done),
    .error_misalign_o (err_mis),
    .error_overflow_o (err_ovf),
    .mem_addr_o       (m_addr),
    .mem_wdata_o      (m_wdata),
    .mem_we_o         (m_we),
    .mem_re_o         (m_re),
    .mem_rdata_i      (m_rdata)
  );

  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
    if (m_re) m_rdata <= mem[m_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it until done_o (or a cycle budget expires).
  // Returns the done cycle (-1 on timeout), strobe counts, and flags seen in cycle 1.
  task automatic run_req(input logic rd, input logic wr, input logic [1:0] num,
                         input logic u, input logic [31:0] a, input logic [31:0] d,
                         output int done_cyc, output int we_cnt, output int re_cnt,
                         output logic mis_c1, output logic ovf_c1);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    req_valid = 1'b1; mem_read = rd; mem_write = wr; mem_num = num;
    uns = u; addr = a; wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_num = 2'b00;
    addr = 32'hDEAD_BEEF; wdata = 32'hCAFE_F00D;
    done_cyc = -1; we_cnt = 0; re_cnt = 0;
    mis_c1 = err_mis; ovf_c1 = err_ovf;
    for (int c = 1; c <= 12; c++) begin
      if (m_we) we_cnt++;
      if (m_re) re_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_num = 2'b00; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_flags", {30'd0, err_mis, err_ovf}, 32'd0);
    chk("rst_strobes", {30'd0, m_we, m_re}, 32'd0);
    chk("rst_addr_wdata", {14'd0, m_addr, m_wdata}, 32'd0);
    rst = 1'b0;

    // Word store: bytes in big-endian order at 0x10..0x13
    run_req(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h1122_3344, dc, wec, rec, mis1, ovf1);
    chk("wst_done_cyc", 32'(dc), 32'd5);
    chk("wst_we_cnt", 32'(wec), 32'd4);
    chk("wst_re_cnt", 32'(rec), 32'd0);
    chk("wst_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'h1122_3344);
    chk("wst_flags", {30'd0, err_mis, err_ovf}, 32'd0);

    run_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, dc, wec, rec, mis1, ovf1);
    chk("wld_done_cyc", 32'(dc), 32'd6);
    chk("wld_re_cnt", 32'(rec), 32'd4);
    chk("wld_data", data_o, 32'h1122_3344);

    run_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h1234_5684, dc, wec, rec, mis1, ovf1);
    chk("bst_done_cyc", 32'(dc), 32'd2);
    chk("bst_mem", {24'd0, mem[19]}, 32'h84);

    run_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, dc, wec, rec, mis1, ovf1);
    chk("bld_s_done_cyc", 32'(dc), 32'd3);
    chk("bld_s_data", data_o, 32'hFFFF_FF84);
    run_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, dc, wec, rec, mis1, ovf1);
    chk("bld_u_data", data_o, 32'h0000_0084);

    // Half store keeps only the low 16 bits of the store data
    run_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hABCD_8001, dc, wec, rec, mis1, ovf1);
    chk("hst_done_cyc", 32'(dc), 32'd3);
    chk("hst_mem", {16'd0, mem[32], mem[33]}, 32'h0000_8001);

    run_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, dc, wec, rec, mis1, ovf1);
    chk("hld_s_done_cyc", 32'(dc), 32'd4);
    chk("hld_s_data", data_o, 32'hFFFF_8001);
    run_req(1'b1, 1'b0, 2'b10, 1'b1, 32'h20, 32'h0, dc, wec, rec, mis1, ovf1);
    chk("hld_u_data", data_o, 32'h0000_8001);

    run_req(1'b0, 1'b1, 2'b11, 1'b0, 32'h12, 32'h5555_5555, dc, wec, rec, mis1, ovf1);
    chk("mis_w_done_cyc", 32'(dc), 32'd1);
    chk("mis_w_flags", {30'd0, err_mis, err_ovf}, 32'd2);
    chk("mis_w_we_cnt", 32'(wec), 32'd0);
    chk("mis_w_data_hold", data_o, 32'h0000_8001);

    run_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, dc, wec, rec, mis1, ovf1);
    chk("mis_h_done_cyc", 32'(dc), 32'd1);
    chk("mis_h_flags", {30'd0, err_mis, err_ovf}, 32'd2);
    chk("mis_h_re_cnt", 32'(rec), 32'd0);

    run_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h3FF, 32'h0000_005A, dc, wec, rec, mis1, ovf1);
    chk("mis_cleared_c1", 32'(mis1), 32'd0);
    chk("top_bst_done_cyc", 32'(dc), 32'd2);
    chk("top_bst_flags", {30'd0, err_mis, err_ovf}, 32'd0);
    chk("top_bst_mem", {24'd0, mem[1023]}, 32'h5A);

    run_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h3FF, 32'h0, dc, wec, rec, mis1, ovf1);
    chk("top_bld_done_cyc", 32'(dc), 32'd3);
    chk("top_bld_data", data_o, 32'h0000_005A);

    run_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h400, 32'h77, dc, wec, rec, mis1, ovf1);
    chk("ovf_b_done_cyc", 32'(dc), 32'd1);
    chk("ovf_b_flags", {30'd0, err_mis, err_ovf}, 32'd1);
    chk("ovf_b_we_cnt", 32'(wec), 32'd0);

    run_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h3FE, 32'h0, dc, wec, rec, mis1, ovf1);
    chk("both_done_cyc", 32'(dc), 32'd1);
    chk("both_flags", {30'd0, err_mis, err_ovf}, 32'd3);

    run_req(1'b1, 1'b0, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'h0, dc, wec, rec, mis1, ovf1);
    chk("wrap_flags", {30'd0, err_mis, err_ovf}, 32'd1);
    chk("wrap_re_cnt", 32'(rec), 32'd0);

    // No-op requests: size none, and read+write both asserted
    run_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, dc, wec, rec, mis1, ovf1);
    chk("noop_sz_done_cyc", 32'(dc), 32'd1);
    chk("noop_sz_flags", {30'd0, err_mis, err_ovf}, 32'd0);
    chk("noop_sz_data_hold", data_o, 32'h0000_005A);
    run_req(1'b1, 1'b1, 2'b11, 1'b0, 32'h10, 32'h9999_9999, dc, wec, rec, mis1, ovf1);
    chk("noop_rw_done_cyc", 32'(dc), 32'd1);
    chk("noop_rw_strobes", 32'(wec + rec), 32'd0);
    chk("noop_rw_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'h1122_3384);

    // Reset after two bytes of a word store
    while (!req_ready) begin @(posedge clk); #1; end
    req_valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0; mem_num = 2'b11;
    addr = 32'h40; wdata = 32'hAABB_CCDD;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_we", 32'(m_we), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    chk("rstmid_data", data_o, 32'd0);
    extra_done = 0; extra_we = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) extra_done++;
      if (m_we) extra_we++;
      @(posedge clk); #1;
    end
    chk("rstmid_no_done", 32'(extra_done), 32'd0);
    chk("rstmid_no_we", 32'(extra_we), 32'd0);
    chk("rstmid_mem", {mem[64], mem[65], mem[66], mem[67]}, 32'hAABB_0000);

    run_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h41, 32'h0, dc, wec, rec, mis1, ovf1);
    chk("post_rst_done_cyc", 32'(dc), 32'd3);
    chk("post_rst_data", data_o, 32'h0000_00BB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
